down_counter_arbiter: RTL and testbench
=======================================

// Module: down_counter_arbiter
// PURPOSE
//  Shares one CNT_W-bit down-counter between NUM_REQ requesters that each need a timed countdown.
//  A round-robin arbiter grants the counter to one requester at a time.
//  A 4-state FSM then loads that requester's start value, counts down to zero and pulses its done bit.
//  Sits between requesting blocks and the shared counter; it is the counter's only controller.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  CNT_W    4  counter width in bits
// PORTS
//  clk       in   1              single clock, rising edge
//  reset     in   1              asynchronous, active-high; clears all state immediately
//  req       in   NUM_REQ        level request per requester; held until done or intentionally dropped
//  load_val  in   NUM_REQ*CNT_W  requester i start value at [i*CNT_W +: CNT_W]
//  pause     in   1              freeze count (present only when DOWN_CNT_PAUSE_EN is defined)
//  grant     out  NUM_REQ        one-hot owner of counter; all-zero when idle
//  done      out  NUM_REQ        one-cycle pulse to owner when count reaches 0
//  count     out  CNT_W          current counter value
//  busy      out  1              high whenever state != IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, grant=0, done=0, count=0, busy=0; rr pointer=0 (requester 0 first).
//  All outputs are registered. The FSM has four states: IDLE, LOAD, COUNT, DONE.
//  IDLE
//   - If any req bit is set, choose the first set bit at or after the pointer, wrapping around.
//   - Next edge: grant=onehot(winner), state=LOAD.
//  LOAD
//   - count <= load_val[winner]. This is the only sampling point; later load_val changes are ignored.
//   - Next state is COUNT, or DONE if the loaded value is 0.
//  COUNT
//   - count <= count-1 each edge.
//   - When count==1, the next state is DONE, so count==0 on entry to DONE.
//   - count never wraps below 0.
//  DONE
//   - done[winner]=1 for exactly this one cycle; grant is still held.
//   - Next edge: grant=0, done=0, state=IDLE, pointer <= winner+1 (mod NUM_REQ).
//  Latency
//   - grant rises 1 clock after req is sampled in IDLE.
//   - done rises N+1 clocks after grant rises, where N is the loaded value (N=0 gives 1 clock).
//   - Back-to-back grants are separated by at least 1 IDLE cycle.
//  Abort
//   - If req[winner] drops in LOAD or COUNT: next edge grant=0, state=IDLE, no done pulse, count holds.
//   - The pointer advances past the aborted requester.
//   - A req drop during the DONE cycle has no effect; done still pulses.
//  Other requests
//   - Requests from non-owners during LOAD, COUNT or DONE are ignored until IDLE, then arbitrated fairly.
//   - An owner that holds req through DONE re-competes in IDLE at lowest priority.
//  Reset mid-operation: all outputs return to reset values asynchronously; no done is issued.
// CONFIGURATION
//  Macro DOWN_CNT_PAUSE_EN.
//  Defined
//   - The pause port exists.
//   - pause=1 in COUNT holds both count and state; pause is ignored in IDLE, LOAD and DONE.
//   - Abort still applies while paused.
//   - done is delayed by exactly the number of paused COUNT cycles.
//  Undefined: no pause port; COUNT decrements every cycle.
// TESTING
//  1 reset=1 for 20 time units -> grant=0, done=0, count=0, busy=0. Release -> remains idle with req=0.
//  2 req=0001, load_val[3:0]=5
//     -> grant=0001 after 1 clk.
//     -> count sequence 5,4,3,2,1,0.
//     -> done=0001 for 1 clk, 6 clks after grant.
//     -> grant=0 next clk.
//  3 req=1111 held, all load_val=2 -> grant order 0001,0010,0100,1000,0001; each done pulses once per grant.
//  4 req=0100, load_val[11:8]=0 -> LOAD then DONE; done=0100 1 clk after grant; count=0.
//  5 req[2] dropped while count=3 -> next clk grant=0, busy=0, count stays 3, no done pulse.
//  6 reset asserted at count=4 -> outputs 0 immediately.
//     With DOWN_CNT_PAUSE_EN: pause=1 for 3 clks at count=3 -> count holds 3, done is 3 clks later.

Source files
------------

// File: rtl/down_counter_arbiter.sv
// down_counter_arbiter: one shared CNT_W-bit down-counter time-shared between
// NUM_REQ requesters. A round-robin arbiter picks an owner. A four-state FSM
// (IDLE/LOAD/COUNT/DONE) then loads that owner's start value, counts it down
// to zero and pulses the owner's done bit.
// Optional feature macro: DOWN_CNT_PAUSE_EN adds pause_i, which freezes COUNT.
module down_counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*CNT_W-1:0] load_val_i,
`ifdef DOWN_CNT_PAUSE_EN
    input  logic                     pause_i,
`endif
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic [CNT_W-1:0]         count_o,
    output logic                     busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

    state_t             state_q,  state_d;
    logic [NUM_REQ-1:0] grant_q,  grant_d;
    logic [NUM_REQ-1:0] done_q,   done_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               busy_q,   busy_d;
    logic [IDX_W-1:0]   ptr_q,    ptr_d;
    logic [IDX_W-1:0]   winner_q, winner_d;

    logic [CNT_W-1:0]   load_arr [NUM_REQ];
    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx;
    logic               pause_hold;
    logic               owner_req;
    logic [CNT_W-1:0]   sel_load;
    logic [IDX_W-1:0]   ptr_after_winner;

    // Per-requester start values and the rotated search order starting at the pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign load_arr[gi] = load_val_i[gi*CNT_W +: CNT_W];
        assign cand_idx[gi] = IDX_W'((int'(ptr_q) + gi) % NUM_REQ);
    end

`ifdef DOWN_CNT_PAUSE_EN
    assign pause_hold = pause_i;
`else
    assign pause_hold = 1'b0;
`endif

    assign owner_req        = req_i[winner_q];
    assign sel_load         = load_arr[winner_q];
    assign ptr_after_winner = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;

    // Round-robin pick: first set request at or after the pointer, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!arb_found && req_i[cand_idx[k]]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx[k];
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/LOAD/COUNT/DONE sequence.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        count_d  = count_q;
        busy_d   = busy_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    winner_d = arb_idx;
                    grant_d  = NUM_REQ'(1) << arb_idx;
                    state_d  = LOAD;
                    busy_d   = 1'b1;
                end
            end
            LOAD: begin
                if (!owner_req) begin
                    // Owner withdrew: release without loading; count keeps its old value.
                    grant_d = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_after_winner;
                end else begin
                    count_d = sel_load;
                    if (sel_load == '0) begin
                        state_d = DONE;
                        done_d  = grant_q;
                    end else begin
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                if (!owner_req) begin
                    grant_d = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_after_winner;
                end else if (!pause_hold) begin
                    // Reaching zero moves to DONE on the same edge, so zero is never passed.
                    if (count_q <= CNT_W'(1)) begin
                        count_d = '0;
                        state_d = DONE;
                        done_d  = grant_q;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
                busy_d  = 1'b0;
                ptr_d   = ptr_after_winner;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            ptr_q    <= '0;
            winner_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
        end
    end

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign count_o = count_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_down_counter_arbiter.sv
// Directed bench for down_counter_arbiter (NUM_REQ=4, CNT_W=4). Expected
// per-cycle outputs are queued as stimulus is applied, then popped and
// compared after the following clock edge.
module tb_down_counter_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] load_val;
`ifdef DOWN_CNT_PAUSE_EN
    logic        pause;
`endif
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [3:0]  count;
    logic        busy;

    typedef struct {
        logic [3:0] g;
        logic [3:0] d;
        logic [3:0] c;
        logic       b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    down_counter_arbiter #(.NUM_REQ(4), .CNT_W(4)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .req_i      (req),
        .load_val_i (load_val),
`ifdef DOWN_CNT_PAUSE_EN
        .pause_i    (pause),
`endif
        .grant_o    (grant),
        .done_o     (done),
        .count_o    (count),
        .busy_o     (busy)
    );

    task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [3:0] d, input logic [3:0] c, input logic b);
        exp_t e;
        e.g = g; e.d = d; e.c = c; e.b = b;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            cmp({tag, ".grant"}, grant, e.g);
            cmp({tag, ".done"},  done,  e.d);
            cmp({tag, ".count"}, count, e.c);
            cmp({tag, ".busy"},  {3'b000, busy}, {3'b000, e.b});
            $display("%0t %s grant=%b done=%b count=%0d busy=%b", $time, tag, grant, done, count, busy);
        end
    endtask

    // Check outputs right now (used for asynchronous reset effects).
    task automatic now_chk(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic [3:0] c, input logic b);
        push(g, d, c, b);
        pop_check(tag);
    endtask

    // Expect these outputs after the next rising edge; sample on the falling edge.
    task automatic tick(input string tag, input logic [3:0] g, input logic [3:0] d,
                        input logic [3:0] c, input logic b);
        push(g, d, c, b);
        @(posedge clk);
        @(negedge clk);
        pop_check(tag);
    endtask

    initial begin
        logic [3:0] g;
        reset    = 1'b1;
        req      = 4'b0000;
        load_val = 16'h0000;
`ifdef DOWN_CNT_PAUSE_EN
        pause    = 1'b0;
`endif
        // 1: reset state, then remain idle with no requests
        #10;
        now_chk("t1_reset", 4'b0000, 4'b0000, 4'd0, 1'b0);
        #10;
        reset = 1'b0;
        tick("t1_idle0", 4'b0000, 4'b0000, 4'd0, 1'b0);
        tick("t1_idle1", 4'b0000, 4'b0000, 4'd0, 1'b0);

        // 2: single requester, start value 5
        req      = 4'b0001;
        load_val = 16'h0005;
        tick("t2_grant", 4'b0001, 4'b0000, 4'd0, 1'b1);
        tick("t2_c5",    4'b0001, 4'b0000, 4'd5, 1'b1);
        tick("t2_c4",    4'b0001, 4'b0000, 4'd4, 1'b1);
        tick("t2_c3",    4'b0001, 4'b0000, 4'd3, 1'b1);
        tick("t2_c2",    4'b0001, 4'b0000, 4'd2, 1'b1);
        tick("t2_c1",    4'b0001, 4'b0000, 4'd1, 1'b1);
        tick("t2_done",  4'b0001, 4'b0001, 4'd0, 1'b1);
        req = 4'b0000;
        tick("t2_rel",   4'b0000, 4'b0000, 4'd0, 1'b0);
        tick("t2_idle",  4'b0000, 4'b0000, 4'd0, 1'b0);

        // Return the pointer to requester 0 before the fairness run
        reset = 1'b1;
        #1;
        now_chk("t3_prereset", 4'b0000, 4'b0000, 4'd0, 1'b0);
        tick("t3_prereset_hold", 4'b0000, 4'b0000, 4'd0, 1'b0);
        reset = 1'b0;

        // 3: all requesting, all start values 2 -> strict rotation
        req      = 4'b1111;
        load_val = 16'h2222;
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << (k % 4);
            tick($sformatf("t3_g%0d_grant", k), g, 4'b0000, 4'd0, 1'b1);
            tick($sformatf("t3_g%0d_c2", k),    g, 4'b0000, 4'd2, 1'b1);
            tick($sformatf("t3_g%0d_c1", k),    g, 4'b0000, 4'd1, 1'b1);
            tick($sformatf("t3_g%0d_done", k),  g, g,       4'd0, 1'b1);
            if (k == 4) req = 4'b0000;
            tick($sformatf("t3_g%0d_idle", k),  4'b0000, 4'b0000, 4'd0, 1'b0);
        end

        // 4: zero start value goes LOAD -> DONE
        req      = 4'b0100;
        load_val = 16'h1000;
        tick("t4_grant", 4'b0100, 4'b0000, 4'd0, 1'b1);
        tick("t4_done",  4'b0100, 4'b0100, 4'd0, 1'b1);
        req = 4'b0000;
        tick("t4_rel",   4'b0000, 4'b0000, 4'd0, 1'b0);

        // 5: owner drops request mid-count
        req      = 4'b0100;
        load_val = 16'h0500;
        tick("t5_grant", 4'b0100, 4'b0000, 4'd0, 1'b1);
        tick("t5_c5",    4'b0100, 4'b0000, 4'd5, 1'b1);
        tick("t5_c4",    4'b0100, 4'b0000, 4'd4, 1'b1);
        tick("t5_c3",    4'b0100, 4'b0000, 4'd3, 1'b1);
        req = 4'b0000;
        tick("t5_abort", 4'b0000, 4'b0000, 4'd3, 1'b0);
        tick("t5_idle",  4'b0000, 4'b0000, 4'd3, 1'b0);

        // 6: reset in the middle of a countdown (pointer now at requester 3)
        req      = 4'b1000;
        load_val = 16'h6000;
        tick("t6_grant", 4'b1000, 4'b0000, 4'd3, 1'b1);
        tick("t6_c6",    4'b1000, 4'b0000, 4'd6, 1'b1);
        tick("t6_c5",    4'b1000, 4'b0000, 4'd5, 1'b1);
        tick("t6_c4",    4'b1000, 4'b0000, 4'd4, 1'b1);
        reset = 1'b1;
        #1;
        now_chk("t6_async_reset", 4'b0000, 4'b0000, 4'd0, 1'b0);
        tick("t6_reset_hold", 4'b0000, 4'b0000, 4'd0, 1'b0);
        reset = 1'b0;
        req   = 4'b0000;
        tick("t6_idle", 4'b0000, 4'b0000, 4'd0, 1'b0);

`ifdef DOWN_CNT_PAUSE_EN
        // 7: pause for 3 cycles at count 3 delays done by 3 cycles
        req      = 4'b0001;
        load_val = 16'h0005;
        tick("t7_grant", 4'b0001, 4'b0000, 4'd0, 1'b1);
        tick("t7_c5",    4'b0001, 4'b0000, 4'd5, 1'b1);
        tick("t7_c4",    4'b0001, 4'b0000, 4'd4, 1'b1);
        tick("t7_c3",    4'b0001, 4'b0000, 4'd3, 1'b1);
        pause = 1'b1;
        tick("t7_p1",    4'b0001, 4'b0000, 4'd3, 1'b1);
        tick("t7_p2",    4'b0001, 4'b0000, 4'd3, 1'b1);
        tick("t7_p3",    4'b0001, 4'b0000, 4'd3, 1'b1);
        pause = 1'b0;
        tick("t7_c2",    4'b0001, 4'b0000, 4'd2, 1'b1);
        tick("t7_c1",    4'b0001, 4'b0000, 4'd1, 1'b1);
        tick("t7_done",  4'b0001, 4'b0001, 4'd0, 1'b1);
        req = 4'b0000;
        tick("t7_rel",   4'b0000, 4'b0000, 4'd0, 1'b0);
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
